// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave controller blocks.
// The cook timer stores time as four BCD digits with no normalization.
package microondas_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX         = 4'd9;
    localparam bcd_t SEC_TENS_RELOAD = 4'd5;
    localparam int   TICKS_PER_SEC_DEFAULT = 100;

    // True when all four digits of an MM:SS value are zero.
    function automatic logic bcd_time_zero(input bcd_t mt, input bcd_t mo,
                                           input bcd_t st, input bcd_t so);
        return (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
    endfunction

endpackage

// File: rtl/cook_timer_bcd_down_digit.sv
// One registered BCD down-counting digit with borrow chaining.
// Clear beats load, load beats decrement; the parent keeps load and decrement exclusive.
module bcd_down_digit
    import microondas_pkg::*;
#(
    parameter bcd_t RELOAD = BCD_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic dec_in,
    output bcd_t q_o,
    output logic borrow_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (load_i) begin
            digit_d = load_val_i;
        end else if (dec_in) begin
            digit_d = (digit_q == 4'd0) ? RELOAD : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_o        = digit_q;
    assign borrow_out = (digit_q == 4'd0) && dec_in;

endmodule

// File: rtl/cook_timer.sv
// Microwave countdown timer: keypad entry into a BCD MM:SS register and a
// once-per-second borrow-chained decrement while the magnetron runs.
module cook_timer
    import microondas_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic load_en,
    input  bcd_t load_digit,
    input  logic clear,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic timer_done,
    output logic done_pulse
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          timer_done_q;
    logic          done_pulse_q;
    logic          done_pulse_d;
    logic          dec_last_q;

    bcd_t mt_q;
    bcd_t mo_q;
    bcd_t st_q;
    bcd_t so_q;

    logic clr_accept;
    logic digit_accept;
    logic counting;
    logic tick;
    logic time_zero;
    logic dec_en;
    logic so_borrow;
    logic st_borrow;
    logic mo_borrow;
    logic mt_borrow;

    // Entry controls only act while the magnetron is off; clear wins over a digit.
    assign clr_accept   = clear && !run;
    assign digit_accept = load_en && !run && !clear && (load_digit <= BCD_MAX);

    assign counting  = run && !timer_done_q;
    assign tick      = counting && (presc_q == PRESC_LAST);
    assign time_zero = bcd_time_zero(mt_q, mo_q, st_q, so_q);
    // Guard on the live digits so 00:00 can never wrap to 99:99.
    assign dec_en    = tick && !time_zero;

    always_comb begin
        presc_d = presc_q;
        if (clr_accept || digit_accept) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // A pulse only when the register reached zero through a decrement.
    assign done_pulse_d = dec_last_q && time_zero && !timer_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            timer_done_q <= 1'b1;
            done_pulse_q <= 1'b0;
            dec_last_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            timer_done_q <= time_zero;
            done_pulse_q <= done_pulse_d;
            dec_last_q   <= dec_en;
        end
    end

    // Keypad entry shifts left: each digit loads its right-hand neighbour.
    bcd_down_digit #(.RELOAD(BCD_MAX)) u_sec_ones (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_accept),
        .load_i     (digit_accept),
        .load_val_i (load_digit),
        .dec_in     (dec_en),
        .q_o        (so_q),
        .borrow_out (so_borrow)
    );

    bcd_down_digit #(.RELOAD(SEC_TENS_RELOAD)) u_sec_tens (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_accept),
        .load_i     (digit_accept),
        .load_val_i (so_q),
        .dec_in     (so_borrow),
        .q_o        (st_q),
        .borrow_out (st_borrow)
    );

    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_ones (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_accept),
        .load_i     (digit_accept),
        .load_val_i (st_q),
        .dec_in     (st_borrow),
        .q_o        (mo_q),
        .borrow_out (mo_borrow)
    );

    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_tens (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_accept),
        .load_i     (digit_accept),
        .load_val_i (mo_q),
        .dec_in     (mo_borrow),
        .q_o        (mt_q),
        .borrow_out (mt_borrow)
    );

    assign min_tens   = mt_q;
    assign min_ones   = mo_q;
    assign sec_tens   = st_q;
    assign sec_ones   = so_q;
    assign timer_done = timer_done_q;
    assign done_pulse = done_pulse_q;

    // The top digit's borrow only fires at 00:00, which dec_en already excludes.
    logic unused_borrow;
    assign unused_borrow = mt_borrow;

endmodule
